// File: rtl/axi_line_fill.sv
// AXI4 read-burst line-fill engine: takes one cache-line miss, issues a single
// INCR burst on AR, assembles the R beats and returns the line with an error flag.
module axi_line_fill #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_dest,
  output logic                    req_ready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [LINE_BYTES*8-1:0] line_data,
  output logic                    line_dest,
  output logic                    line_err,
  output logic                    line_valid,
  output logic                    busy
);

  localparam int unsigned BEATS  = LINE_BYTES * 8 / DATA_WIDTH;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SIZE   = $clog2(DATA_WIDTH / 8);
  localparam int unsigned LINE_W = LINE_BYTES * 8;

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_RDATA,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    dest_q, dest_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic                    last_slot;

  // RID carries no information for a single outstanding burst.
  logic rid_unused;
  assign rid_unused = ^m_axi_rid;

  assign last_slot = (cnt_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dest_d  = dest_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr & ~LINE_MASK;
          dest_d  = req_dest;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_AR;
        end
      end
      S_AR: begin
        if (m_axi_arready) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (m_axi_rvalid) begin
          for (int unsigned i = 0; i < BEATS; i++) begin
            if (cnt_q == CNT_W'(i)) line_d[i*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (m_axi_rresp != 2'b00) err_d = 1'b1;
          // Burst ends on whichever comes first; disagreement means a malformed burst.
          if (m_axi_rlast || last_slot) begin
            state_d = S_DONE;
            if (m_axi_rlast != last_slot) err_d = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      dest_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dest_q  <= dest_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign m_axi_arvalid = (state_q == S_AR);
  assign m_axi_rready  = (state_q == S_RDATA);
  assign line_valid    = (state_q == S_DONE);

  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arid    = ID_WIDTH'(AXI_ID);

  assign line_data     = line_q;
  assign line_dest     = dest_q;
  assign line_err      = err_q;

endmodule

// File: tb/tb_axi_line_fill.sv
// Scoreboard bench for axi_line_fill: a driver plays arbiter and AXI slave and
// pushes expected lines; a negedge monitor pops and compares on line_valid.
module tb_axi_line_fill;
  localparam int AW = 64, DW = 64, LB = 64, IW = 4, BEATS = 8, LW = LB * 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_dest, req_ready;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [IW-1:0] arid, rid;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  logic [LW-1:0] line_data;
  logic          line_dest, line_err, line_valid, busy;

  axi_line_fill #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_BYTES(LB), .ID_WIDTH(IW), .AXI_ID(0)
  ) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_dest(req_dest), .req_ready(req_ready),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arid(arid), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rlast(rlast), .m_axi_rid(rid), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .line_data(line_data), .line_dest(line_dest), .line_err(line_err),
    .line_valid(line_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [LW-1:0] data;
    logic          dest;
    logic          err;
    int unsigned   at_cyc;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [LW-1:0] model_line = '0;
  int unsigned   last_lv_cyc = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic give_up(input string why);
    errors++;
    $display("FAIL %s: timeout", why);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "aborted");
  endtask

  // Monitor: every line_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && line_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_line_valid: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("line_data", line_data, e.data);
        chk("line_dest", LW'(line_dest), LW'(e.dest));
        chk("line_err", LW'(line_err), LW'(e.err));
        chk("line_cycle", LW'(cyc), LW'(e.at_cyc));
        last_lv_cyc = cyc;
      end
    end
  end

  // One transaction. rlast_pos: beat (1-based) carrying rlast, BEATS+1 = never.
  // abort_after > 0 asserts reset once that many beats have been accepted.
  task automatic run_txn(input logic [AW-1:0] addr, input logic dest, input int rlast_pos,
                         input logic [7:0] err_mask, input int ar_delay, input int gmin,
                         input int gmax, input bit b2b, input int abort_after,
                         input bit seq_data, output int unsigned acc_cyc);
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] nl;
    logic [DW-1:0] d;
    logic          e;
    int            nb, t;
    exp_addr = addr & ~(AW'(LB - 1));
    acc_cyc  = 0;
    if (!b2b) repeat ($urandom_range(0, 2)) @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    req_dest  = dest;
    if (b2b) begin
      chk("b2b_ready_in_done", LW'(req_ready), LW'(0));
      @(negedge clk);
    end
    t = 0;
    while (!req_ready) begin
      @(negedge clk);
      if (++t > 50) give_up("req_ready_wait");
    end
    acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_dest  = 1'($urandom);
    for (int i = 0; i <= ar_delay; i++) begin
      arready = (i == ar_delay);
      rvalid  = 1'($urandom);
      rdata   = {$urandom, $urandom};
      rlast   = 1'($urandom);
      chk("arvalid", LW'(arvalid), LW'(1));
      chk("araddr", LW'(araddr), LW'(exp_addr));
      chk("arlen", LW'(arlen), LW'(BEATS - 1));
      chk("arsize_burst_id", LW'({arsize, arburst, arid}), LW'({3'd3, 2'b01, 4'd0}));
      chk("ar_busy_ready", LW'({busy, req_ready, rready}), LW'(3'b100));
      @(negedge clk);
    end
    arready = 1'b0;
    chk("arvalid_drop", LW'(arvalid), LW'(0));
    nb = (rlast_pos > BEATS) ? BEATS : rlast_pos;
    nl = model_line;
    e  = (rlast_pos != BEATS);
    for (int b = 0; b < nb; b++) begin
      if (abort_after > 0 && b == abort_after) begin
        rvalid = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", LW'(req_ready), LW'(1));
        chk("rst_rready_arvalid", LW'({rready, arvalid}), LW'(0));
        chk("rst_busy_lv", LW'({busy, line_valid}), LW'(0));
        chk("rst_line_data", line_data, '0);
        chk("rst_dest_err", LW'({line_dest, line_err}), LW'(0));
        model_line = '0;
        reset = 1'b1;
        return;
      end
      repeat ($urandom_range(gmin, gmax)) begin
        rvalid = 1'b0;
        rdata  = {$urandom, $urandom};
        @(negedge clk);
      end
      d      = seq_data ? DW'(17 * (b + 1)) : {$urandom, $urandom};
      rvalid = 1'b1;
      rdata  = d;
      rresp  = err_mask[b] ? 2'($urandom_range(1, 3)) : 2'b00;
      rlast  = (b + 1 == rlast_pos);
      t = 0;
      while (!rready) begin
        @(negedge clk);
        if (++t > 50) give_up("rready_wait");
      end
      nl[b*DW +: DW] = d;
      if (rresp != 2'b00) e = 1'b1;
      if (b == nb - 1) begin
        exp_q.push_back('{nl, dest, e, cyc + 1});
        model_line = nl;
      end
      @(negedge clk);
    end
    chk("rready_done", LW'(rready), LW'(0));
    rvalid = 1'b1;
    rdata  = {$urandom, $urandom};
    rresp  = 2'b10;
    rlast  = 1'($urandom);
  endtask

  initial begin
    int unsigned acc;
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_dest = 1'b0;
    arready = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0; rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", LW'(req_ready), LW'(1));
    chk("reset_ctrl", LW'({arvalid, rready, line_valid, busy}), LW'(0));
    chk("reset_line", line_data, '0);
    reset = 1'b1;
    @(negedge clk);

    // Basic zero-wait fill with the 0x11..0x88 data pattern.
    run_txn(64'h1000_0038, 1'b1, BEATS, 8'h00, 0, 0, 0, 1'b0, 0, 1'b1, acc);
    @(negedge clk);
    chk("basic_latency", LW'(last_lv_cyc), LW'(acc + 10));
    chk("basic_beat0", LW'(line_data[63:0]), LW'(64'h11));
    chk("basic_beat7", LW'(line_data[511:448]), LW'(64'h88));
    // Backpressure on AR and every-other-cycle R.
    run_txn(64'h2000_1234, 1'b0, BEATS, 8'h00, 5, 1, 1, 1'b0, 0, 1'b0, acc);
    // Error response on beat 3.
    run_txn(64'h3000_0040, 1'b1, BEATS, 8'h08, 1, 0, 1, 1'b0, 0, 1'b0, acc);
    // Short burst: rlast on beat 5.
    run_txn(64'h4000_007f, 1'b0, 5, 8'h00, 0, 0, 0, 1'b0, 0, 1'b0, acc);
    // No rlast at all: burst ends on the final slot with err.
    run_txn(64'h4800_0001, 1'b1, BEATS + 1, 8'h00, 0, 0, 1, 1'b0, 0, 1'b0, acc);
    // Reset after three beats, then a normal request.
    run_txn(64'h5000_0010, 1'b1, BEATS, 8'h00, 0, 0, 0, 1'b0, 3, 1'b0, acc);
    run_txn(64'h5000_0080, 1'b1, BEATS, 8'h00, 0, 0, 0, 1'b0, 0, 1'b0, acc);
    // Back-to-back: next request held high during DONE.
    run_txn(64'h6000_0000, 1'b0, BEATS, 8'h00, 0, 0, 0, 1'b1, 0, 1'b0, acc);

    for (int n = 0; n < 30; n++) begin
      int rp;
      logic [7:0] m;
      rp = ($urandom_range(0, 9) < 7) ? BEATS : $urandom_range(1, BEATS + 1);
      m  = ($urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      run_txn({$urandom, $urandom}, 1'($urandom), rp, m, $urandom_range(0, 3), 0, 2,
              ($urandom_range(0, 3) == 0), 0, 1'b0, acc);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", LW'(exp_q.size()), LW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    give_up("global_watchdog");
  end

endmodule

// File: doc/axi_line_fill.md
Name: axi_line_fill

Overview:
- AXI4 read-burst engine directly downstream of the I/D cache arbiter.
- Accepts one granted cache-line miss request (address plus requester tag) and issues a single INCR burst on the AXI AR channel.
- Collects the R beats into a full line and returns it, with an error flag, to the requesting cache.
- Only one request is in flight at a time; the arbiter must hold its request until req_ready.

Parameters:
ADDR_WIDTH, 64, request/AXI address width
DATA_WIDTH, 64, AXI R data width in bits (multiple of 8)
LINE_BYTES, 64, cache line size in bytes (power of two, multiple of DATA_WIDTH/8)
ID_WIDTH, 4, AXI ARID/RID width
AXI_ID, 0, constant ARID value driven on every burst

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
req_valid  input  1  arbiter has a granted miss request
req_addr  input  ADDR_WIDTH  miss address (any byte alignment)
req_dest  input  1  requester tag: 0 = I-cache, 1 = D-cache
req_ready  output  1  engine can accept a request
m_axi_araddr  output  ADDR_WIDTH  line-aligned burst address
m_axi_arlen  output  8  BEATS-1
m_axi_arsize  output  3  log2(DATA_WIDTH/8)
m_axi_arburst  output  2  2'b01 (INCR)
m_axi_arid  output  ID_WIDTH  AXI_ID
m_axi_arvalid  output  1  AR valid
m_axi_arready  input  1  AR ready
m_axi_rdata  input  DATA_WIDTH  R data
m_axi_rresp  input  2  R response
m_axi_rlast  input  1  R last
m_axi_rid  input  ID_WIDTH  R ID (ignored)
m_axi_rvalid  input  1  R valid
m_axi_rready  output  1  R ready
line_data  output  LINE_BYTES*8  assembled line; beat i at [i*DATA_WIDTH +: DATA_WIDTH]
line_dest  output  1  requester tag of the returned line
line_err  output  1  error flag for the returned line
line_valid  output  1  one-cycle pulse; line_data, line_dest and line_err are valid
busy  output  1  high in any state other than IDLE

Behaviour:
- BEATS = LINE_BYTES*8/DATA_WIDTH (default 8); the beat counter is $clog2(BEATS) bits wide.
- FSM states:
  - IDLE: req_ready=1. On req_valid: latch araddr = req_addr with the low log2(LINE_BYTES) bits cleared, latch dest, clear err and the beat counter, then go to AR.
  - AR: arvalid=1; araddr, arlen, arsize and arburst are stable. On arready, go to RDATA. arvalid falls on the same edge.
  - RDATA: rready=1. On each rvalid, write rdata into beat slot cnt and increment cnt.
    - rresp != 2'b00 on any beat sets err (sticky).
    - The burst ends on the first beat with rlast=1 or with cnt==BEATS-1.
    - If rlast and cnt==BEATS-1 do not coincide, set err.
    - At burst end, go to DONE; rready falls on the same edge, so no further beats are accepted.
  - DONE: line_valid=1 for exactly one cycle, with line_dest and line_err driven. Go to IDLE.
- Latency: request accepted at edge N; arvalid high in cycle N+1. With arready=1 in that cycle, rready is high from cycle N+2. line_valid pulses in the cycle after the last beat handshake.
- Zero-wait-state best case: 1 (AR) + BEATS (R) + 1 (DONE) = 10 cycles from accept to the line_valid cycle for default parameters.
- line_data, line_dest and line_err hold their values after DONE until the next request is accepted. Only slots actually written change; on a short burst, unwritten slots keep stale data and err=1.
- req_ready=0 outside IDLE. The next request can be accepted no earlier than the cycle after DONE.
- Reset asserted (reset==0) at any clock edge, including mid-burst:
  - state goes to IDLE
  - arvalid, rready, line_valid and busy go to 0; req_ready goes to 1
  - line_data, line_dest, line_err and the internal counter and err go to 0
  - The abandoned burst is not drained; the system resets the AXI slave together with this engine.
- rvalid is ignored outside RDATA. arready is ignored outside AR.

Test Plan:
- Basic fill: req_addr=0x1000_0038, dest=1, arready=1, 8 beats rdata=0x11..0x88 with rlast on beat 8, rresp=0 -> araddr=0x1000_0000, arlen=7, arsize=3, arburst=1; line_valid pulses once 10 cycles after accept with line_dest=1, line_err=0, beat0=0x11 at bits [63:0], beat7=0x88 at bits [511:448].
- Backpressure: arready held low 5 cycles, then rvalid toggling every other cycle -> arvalid and araddr stable throughout; line_valid fires one cycle after the 8th beat; data is correct.
- Error response: beat 3 carries rresp=2'b10 -> all 8 beats still accepted; line_err=1, line_dest matches the request.
- Short burst: rlast asserted on beat 5 -> rready drops after beat 5; line_valid next cycle with line_err=1; slots 0-4 updated.
- Reset mid-burst: reset=0 after 3 beats -> next cycle state IDLE, req_ready=1, rready=0, line_data=0; a following request completes normally.
- Back-to-back: req_valid held high with a new address during DONE -> not accepted until the cycle after line_valid; the second burst completes normally.
